// File: rtl/clock_pkg.sv
// Shared clock-datapath constants and the elaboration-time binary-to-BCD helper.
package clock_pkg;
  localparam int               BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;
  localparam int               MAX_DIGITS = 4;

  // Packs the low 'digits' decimal decades of 'value' into BCD, LS digit in [3:0].
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(int value, int digits);
    logic [BCD_W*MAX_DIGITS-1:0] res;
    int v;
    res = '0;
    v   = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        res[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
        v = v / 10;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/data bundle of one counter stage; master drives controls, slave is the counter.
interface bcd_mod_counter_if
  import clock_pkg::*;
#(
  parameter int DIGITS = 2
);
  // No valid/ready handshake: EN, LD, DN and D are level qualifiers sampled at every
  // rising CP edge; Q and ERR are registered, CO is a same-cycle combinational strobe.
  logic                    EN;
  logic                    LD;
  logic                    DN;
  logic [BCD_W*DIGITS-1:0] D;
  logic [BCD_W*DIGITS-1:0] Q;
  logic                    CO;
  logic                    ERR;

  modport master (output EN, LD, DN, D, input Q, CO, ERR);
  modport slave  (input EN, LD, DN, D, output Q, CO, ERR);
endinterface

// File: rtl/bcd_mod_counter_digit.sv
// One BCD decade: clear > load > step; step_out flags the decade rolling over in 'dir'.
module bcd_digit
  import clock_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             step_in,
  input  logic             dir,
  output logic [BCD_W-1:0] value,
  output logic             step_out
);
  logic [BCD_W-1:0] val_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      val_q <= '0;
    end else if (load) begin
      val_q <= load_val;
    end else if (step_in) begin
      if (dir) val_q <= (val_q == '0) ? BCD_MAX : val_q - 4'd1;
      else     val_q <= (val_q == BCD_MAX) ? '0 : val_q + 4'd1;
    end
  end

  assign value    = val_q;
  assign step_out = step_in & (dir ? (val_q == '0) : (val_q == BCD_MAX));
endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-MODULUS BCD counter with parallel load, cascade carry CO and invalid-load ERR.
// Define BCD_MOD_COUNTER_DOWN_EN to build the DN-selected down-count path.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input logic              CP,
  input logic              CLR,
  bcd_mod_counter_if.slave bus
);
  localparam int W = BCD_W * DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] TERM_FULL = to_bcd(MODULUS - 1, DIGITS);
  localparam logic [W-1:0] TERM_UP = TERM_FULL[W-1:0];

  logic [W-1:0]  q;
  logic [W-1:0]  term;
  logic [W-1:0]  load_val;
  logic [DIGITS:0] step;
  logic          dir;
  logic          at_term;
  logic          wrap;
  logic          digits_ok;
  logic          load_ok;
  logic          err_q;
  logic          unused_step;

`ifdef BCD_MOD_COUNTER_DOWN_EN
  assign dir  = bus.DN;
  assign term = dir ? '0 : TERM_UP;
`else
  logic unused_dn;
  assign unused_dn = bus.DN;
  assign dir  = 1'b0;
  assign term = TERM_UP;
`endif

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.D[i*BCD_W +: BCD_W] > BCD_MAX) digits_ok = 1'b0;
    end
  end

  // With every digit legal, packed BCD ordering equals numeric ordering.
  assign load_ok  = digits_ok && (bus.D <= TERM_UP);
  assign at_term  = (q == term);
  assign wrap     = bus.EN & ~bus.LD & at_term;
  assign load_val = bus.LD ? (load_ok ? bus.D : '0) : (dir ? TERM_UP : '0);
  assign step[0]  = bus.EN & ~bus.LD;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (CP),
      .clr      (CLR),
      .load     (bus.LD | wrap),
      .load_val (load_val[g*BCD_W +: BCD_W]),
      .step_in  (step[g]),
      .dir      (dir),
      .value    (q[g*BCD_W +: BCD_W]),
      .step_out (step[g+1])
    );
  end

  // The terminal compare owns the top-decade rollover, so its ripple-out is never used.
  assign unused_step = step[DIGITS];

  always_ff @(posedge CP) begin
    if (CLR) err_q <= 1'b0;
    else     err_q <= bus.LD & ~load_ok;
  end

  assign bus.Q   = q;
  assign bus.ERR = err_q;
  assign bus.CO  = bus.EN & ~bus.LD & ~CLR & at_term;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: mod-60, mod-24 and a two-stage mod-60 cascade
// checked every cycle against an integer model, plus hand-computed literal points.
module tb_bcd_mod_counter;
`ifdef BCD_MOD_COUNTER_DOWN_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif
  localparam int N = 4;

  logic       clk;
  logic       clr [N];
  logic       en  [N];
  logic       ld  [N];
  logic       dn  [N];
  logic [7:0] d   [N];
  logic [7:0] q_o [N];
  logic       co_o[N];
  logic       err_o[N];

  int  cnt  [N];
  bit  err_m[N];
  bit  checking;
  int  n_vec;
  int  n_err;
  logic [7:0] dn_exp[3];

  // ---------------- clock / DUTs ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bcd_mod_counter_if #(.DIGITS(2)) ia  ();
  bcd_mod_counter_if #(.DIGITS(2)) ih  ();
  bcd_mod_counter_if #(.DIGITS(2)) ic1 ();
  bcd_mod_counter_if #(.DIGITS(2)) ic2 ();

  assign ia.EN  = en[0];  assign ia.LD  = ld[0];  assign ia.DN  = dn[0];  assign ia.D  = d[0];
  assign ih.EN  = en[1];  assign ih.LD  = ld[1];  assign ih.DN  = dn[1];  assign ih.D  = d[1];
  assign ic1.EN = en[2];  assign ic1.LD = ld[2];  assign ic1.DN = dn[2];  assign ic1.D = d[2];
  assign ic2.EN = ic1.CO; assign ic2.LD = ld[3];  assign ic2.DN = dn[3];  assign ic2.D = d[3];

  assign q_o[0] = ia.Q;  assign co_o[0] = ia.CO;  assign err_o[0] = ia.ERR;
  assign q_o[1] = ih.Q;  assign co_o[1] = ih.CO;  assign err_o[1] = ih.ERR;
  assign q_o[2] = ic1.Q; assign co_o[2] = ic1.CO; assign err_o[2] = ic1.ERR;
  assign q_o[3] = ic2.Q; assign co_o[3] = ic2.CO; assign err_o[3] = ic2.ERR;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a  (.CP(clk), .CLR(clr[0]), .bus(ia));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_h  (.CP(clk), .CLR(clr[1]), .bus(ih));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_c1 (.CP(clk), .CLR(clr[2]), .bus(ic1));
  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_c2 (.CP(clk), .CLR(clr[3]), .bus(ic2));

  // ---------------- model ----------------
  function automatic logic [7:0] to_bcd8(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int modulus_of(int i);
    return (i == 1) ? 24 : 60;
  endfunction

  function automatic bit model_co(int i, bit en_eff);
    int t;
    t = (DOWN && dn[i]) ? 0 : modulus_of(i) - 1;
    return en_eff && !ld[i] && !clr[i] && (cnt[i] == t);
  endfunction

  function automatic bit en_eff_of(int i);
    return (i == 3) ? model_co(2, en[2]) : en[i];
  endfunction

  always @(posedge clk) begin : model
    bit e[N];
    int hi, lo, m;
    for (int i = 0; i < N; i++) e[i] = en_eff_of(i);
    for (int i = 0; i < N; i++) begin
      m = modulus_of(i);
      if (clr[i]) begin
        cnt[i] = 0; err_m[i] = 1'b0;
      end else if (ld[i]) begin
        hi = int'(d[i][7:4]);
        lo = int'(d[i][3:0]);
        if (hi <= 9 && lo <= 9 && (hi * 10 + lo) < m) begin
          cnt[i] = hi * 10 + lo; err_m[i] = 1'b0;
        end else begin
          cnt[i] = 0; err_m[i] = 1'b1;
        end
      end else begin
        err_m[i] = 1'b0;
        if (e[i]) begin
          if (DOWN && dn[i]) cnt[i] = (cnt[i] == 0) ? m - 1 : cnt[i] - 1;
          else               cnt[i] = (cnt[i] + 1) % m;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("q[%0d]", i), q_o[i], to_bcd8(cnt[i]));
        check($sformatf("err[%0d]", i), {7'd0, err_o[i]}, {7'd0, err_m[i]});
        check($sformatf("co[%0d]", i), {7'd0, co_o[i]}, {7'd0, model_co(i, en_eff_of(i))});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_q(input string name, input int i, input logic [7:0] exp);
    check(name, q_o[i], exp);
  endtask

  task automatic lit_b(input string name, input logic act, input logic exp);
    check(name, {7'd0, act}, {7'd0, exp});
  endtask

  initial begin
    n_vec = 0; n_err = 0; checking = 1'b0;
    for (int i = 0; i < N; i++) begin
      clr[i] = 1'b1; en[i] = 1'b1; ld[i] = 1'b1; dn[i] = 1'b0; d[i] = 8'h45;
      cnt[i] = 0; err_m[i] = 1'b0;
    end
    if (DOWN) begin dn_exp[0] = 8'h00; dn_exp[1] = 8'h59; dn_exp[2] = 8'h58; end
    else      begin dn_exp[0] = 8'h02; dn_exp[1] = 8'h03; dn_exp[2] = 8'h04; end

    // reset with EN and LD also high, two cycles
    step();
    checking = 1'b1;
    #1 lit_b("rst_co", co_o[0], 1'b0);
    step();
    lit_q("rst_q", 0, 8'h00);
    lit_b("rst_err", err_o[0], 1'b0);
    for (int i = 0; i < N; i++) begin clr[i] = 1'b0; en[i] = 1'b0; ld[i] = 1'b0; end

    // mod-60 up wrap
    ld[0] = 1'b1; d[0] = 8'h58; step();
    lit_q("ld58", 0, 8'h58);
    ld[0] = 1'b0; en[0] = 1'b1;
    #1 lit_b("co_at58", co_o[0], 1'b0);
    step(); lit_q("up59", 0, 8'h59);
    #1 lit_b("co_at59", co_o[0], 1'b1);
    step(); lit_q("wrap00", 0, 8'h00);
    #1 lit_b("co_at00", co_o[0], 1'b0);
    step(); lit_q("up01", 0, 8'h01);
    en[0] = 1'b0;

    // invalid and boundary loads
    ld[0] = 1'b1; d[0] = 8'h61; step();
    lit_q("bad61_q", 0, 8'h00); lit_b("bad61_err", err_o[0], 1'b1);
    d[0] = 8'h1A; step();
    lit_q("bad1A_q", 0, 8'h00); lit_b("bad1A_err", err_o[0], 1'b1);
    d[0] = 8'h45; step();
    lit_q("ld45_q", 0, 8'h45); lit_b("ld45_err", err_o[0], 1'b0);
    d[0] = 8'h59; step();
    lit_q("ld59_q", 0, 8'h59); lit_b("ld59_err", err_o[0], 1'b0);
    d[0] = 8'h60; step();
    lit_q("bad60_q", 0, 8'h00); lit_b("bad60_err", err_o[0], 1'b1);
    ld[0] = 1'b0; step();
    lit_b("err_pulse", err_o[0], 1'b0);

    // down mode (counts up without the macro)
    ld[0] = 1'b1; d[0] = 8'h01; step();
    ld[0] = 1'b0; dn[0] = 1'b1; en[0] = 1'b1;
    step(); lit_q("dn1", 0, dn_exp[0]);
    #1 lit_b("dn_co", co_o[0], DOWN);
    step(); lit_q("dn2", 0, dn_exp[1]);
    step(); lit_q("dn3", 0, dn_exp[2]);
    dn[0] = 1'b0; en[0] = 1'b0;

    // mod-24 decade carry and wrap
    ld[1] = 1'b1; d[1] = 8'h09; step();
    ld[1] = 1'b0; en[1] = 1'b1; step();
    lit_q("h10", 1, 8'h10);
    en[1] = 1'b0; ld[1] = 1'b1; d[1] = 8'h23; step();
    ld[1] = 1'b0; en[1] = 1'b1;
    #1 lit_b("h_co23", co_o[1], 1'b1);
    step(); lit_q("h00", 1, 8'h00);
    en[1] = 1'b0; ld[1] = 1'b1; d[1] = 8'h24; step();
    lit_b("h_bad24", err_o[1], 1'b1);
    ld[1] = 1'b0;

    // cascade 59/59 -> 00/00
    ld[2] = 1'b1; ld[3] = 1'b1; d[2] = 8'h59; d[3] = 8'h59; step();
    ld[2] = 1'b0; ld[3] = 1'b0; en[2] = 1'b1;
    #1 lit_b("c1_co", co_o[2], 1'b1);
    lit_b("c2_co", co_o[3], 1'b1);
    step();
    lit_q("c1_00", 2, 8'h00); lit_q("c2_00", 3, 8'h00);
    en[2] = 1'b0;

    // same cascade with CLR at the wrapping edge
    ld[2] = 1'b1; ld[3] = 1'b1; step();
    ld[2] = 1'b0; ld[3] = 1'b0; en[2] = 1'b1; clr[2] = 1'b1; clr[3] = 1'b1;
    #1 lit_b("c1_co_clr", co_o[2], 1'b0);
    lit_b("c2_co_clr", co_o[3], 1'b0);
    step();
    lit_q("c1_clr", 2, 8'h00); lit_q("c2_clr", 3, 8'h00);
    clr[2] = 1'b0; clr[3] = 1'b0;

    // long free run with a mid-count direction change on stage 0
    en[0] = 1'b1; en[1] = 1'b1;
    for (int k = 0; k < 130; k++) begin
      if (k == 70) dn[0] = 1'b1;
      if (k == 100) dn[0] = 1'b0;
      step();
    end
    en[0] = 1'b0; en[1] = 1'b0; en[2] = 1'b0;
    step();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
